bp_be_dcache_wbuf_drain: RTL and testbench
==========================================

// Module: bp_be_dcache_wbuf_drain
//
// PURPOSE
//   Consumer end of the dcache write buffer: pops committed store entries
//   (v/yumi) and converts each into one banked data-SRAM write. Sits between
//   the wbuf and the data-mem port arbiter. Loads have priority at that
//   arbiter, so the block holds one entry until granted and raises a
//   starvation-priority flag if it is denied for too long.
//
// PARAMETERS
//   data_width_p    64    word width; mask width = data_width_p/8
//   paddr_width_p   56    physical address width
//   ways_p          8     ways = banks = words per block (power of 2)
//   sets_p          64    sets; index width = clog2(sets_p)
//   starve_limit_p  8     denied request cycles before priority_o asserts
//
// PORTS
//   clk_i                   in   1                clock
//   reset_n_i               in   1                async active-low reset
//   v_i                     in   1                wbuf has an entry
//   wbuf_entry_i            in   wbuf_entry_w     {paddr, way_id, data, mask}
//   yumi_o                  out  1                entry consumed this cycle
//   data_mem_v_o            out  1                write request to arbiter
//   data_mem_yumi_i         in   1                arbiter grants request
//   data_mem_index_o        out  index_w          set index
//   data_mem_bank_mask_o    out  ways_p           one-hot bank enable
//   data_mem_data_o         out  ways_p*data_w    data, replicated per bank
//   data_mem_wmask_o        out  ways_p*mask_w    byte mask, selected bank only
//   priority_o              out  1                starvation: force grant
//   idle_o                  out  1                no entry held, none pending
//
// BEHAVIOUR
//   - Clock clk_i; reset is asynchronous and active-low on reset_n_i.
//     While reset_n_i=0: state=IDLE, held entry invalid, starve count=0,
//     every output=0. The held entry is dropped, and the wbuf resets with it.
//   - FSM has two states:
//       IDLE: yumi_o=v_i. If v_i, latch the entry and go to REQ.
//       REQ:  data_mem_v_o=1. If data_mem_yumi_i: yumi_o=v_i; on v_i latch
//             the next entry and stay in REQ, else go to IDLE.
//             If no grant: yumi_o=0, hold the entry and stay in REQ.
//   - Latency: an entry accepted in cycle N is presented in cycle N+1.
//     Throughput is 1 write/cycle while granted every cycle.
//   - Field decode from the held entry:
//       byte_off = clog2(data_w/8); word_off = clog2(ways_p)
//       word = paddr[byte_off+:word_off]
//       index = paddr[(byte_off+word_off)+:index_w]
//       bank = (way_id + word) mod ways_p (wraps, no carry)
//       bank_mask = 1<<bank
//       wmask = entry.mask in lane bank, 0 elsewhere
//   - All data_mem_* outputs are registered, or decoded only from registered
//     state. There is no combinational path from v_i to data_mem_*.
//     yumi_o is combinational from v_i and data_mem_yumi_i.
//   - Starve counter:
//       +1 on each REQ cycle without a grant, saturating at starve_limit_p
//       cleared on a grant or in IDLE
//       priority_o = (count == starve_limit_p)
//   - idle_o = (state==IDLE) & ~v_i. The fence/flush logic waits on idle_o
//     together with wbuf empty.
//   - An entry with mask=0 is still written: one request, all-zero wmask.
//   - data_mem_yumi_i while data_mem_v_o=0 is ignored.
//
// STRUCTURE
//   - The wbuf entry struct macro and the bank-rotation function live in
//     bp_common_pkg. The dcache read path uses the same mapping, so the
//     two must not diverge.
//   - Sub-module bp_be_dcache_wbuf_drain_starve_ctr: saturating
//     counter with clear, parameterised by starve_limit_p.
//     The FSM, latch and decode stay in this module.
//
// TESTING
//   - ways=8, data=64, sets=64. Entry paddr=0x1048, way=3, mask=0x0F, grant
//     immediate -> next cycle data_mem_v_o=1, index=1, bank_mask=0x10,
//     wmask lane4=0x0F, all other lanes 0.
//   - 3 entries back-to-back, data_mem_yumi_i=1 held -> yumi_o high cycles
//     0,1,2; writes in cycles 1,2,3; idle_o=1 from cycle 4.
//   - 1 entry, grant withheld 12 cycles, starve_limit_p=8 -> priority_o
//     rises on the 9th REQ cycle and holds; clears the cycle after grant.
//   - Wrap: way=7, paddr word=7 -> bank_mask=0x40 (bank 6).
//   - Drop reset_n_i mid-REQ with no clock edge -> data_mem_v_o, priority_o
//     drop to 0 immediately. After release: IDLE, no stale write issued.
//   - Grant denied while v_i=1 -> yumi_o stays 0 and the held entry is
//     unchanged until the grant arrives.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared dcache definitions: FSM state, wbuf entry layout and the bank-rotation
// mapping that both the dcache read path and the wbuf drain use.
package bp_common_pkg;

  typedef enum logic {
    e_wbuf_drain_idle = 1'b0,
    e_wbuf_drain_req  = 1'b1
  } wbuf_drain_state_e;

  // Packed wbuf entry is {paddr, way_id, data, mask}, MSB first.
  function automatic int unsigned wbuf_entry_width(input int unsigned paddr_width,
                                                   input int unsigned ways,
                                                   input int unsigned data_width);
    return paddr_width + $clog2(ways) + data_width + data_width / 8;
  endfunction

  // Word w of a block in way v lives in bank (v + w) mod ways.
  function automatic int unsigned bank_rotate(input int unsigned way_id,
                                              input int unsigned word,
                                              input int unsigned ways);
    return (way_id + word) % ways;
  endfunction

endpackage

// File: rtl/bp_be_dcache_wbuf_drain_starve_ctr.sv
// Saturating request-starvation counter; clear wins over increment.
module bp_be_dcache_wbuf_drain_starve_ctr #(
  parameter int unsigned starve_limit_p = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned cnt_w = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w-1:0] limit_lp = cnt_w'(starve_limit_p);

  logic [cnt_w-1:0] count_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_reg <= '0;
    end else if (clr_i) begin
      count_reg <= '0;
    end else if (inc_i && (count_reg != limit_lp)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign sat_o = (count_reg == limit_lp);

endmodule

// File: rtl/bp_be_dcache_wbuf_drain.sv
// Drains committed wbuf stores into banked data-SRAM writes, holding one entry
// until the data-mem arbiter grants it and flagging starvation.
module bp_be_dcache_wbuf_drain
  import bp_common_pkg::*;
#(
  parameter int unsigned data_width_p   = 64,
  parameter int unsigned paddr_width_p  = 56,
  parameter int unsigned ways_p         = 8,
  parameter int unsigned sets_p         = 64,
  parameter int unsigned starve_limit_p = 8,
  localparam int unsigned mask_w        = data_width_p / 8,
  localparam int unsigned way_id_w      = $clog2(ways_p),
  localparam int unsigned index_w       = $clog2(sets_p),
  localparam int unsigned entry_w       = wbuf_entry_width(paddr_width_p, ways_p, data_width_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  input  logic [entry_w-1:0]               wbuf_entry_i,
  output logic                             yumi_o,
  output logic                             data_mem_v_o,
  input  logic                             data_mem_yumi_i,
  output logic [index_w-1:0]               data_mem_index_o,
  output logic [ways_p-1:0]                data_mem_bank_mask_o,
  output logic [ways_p*data_width_p-1:0]   data_mem_data_o,
  output logic [ways_p*mask_w-1:0]         data_mem_wmask_o,
  output logic                             priority_o,
  output logic                             idle_o
);

  localparam int unsigned byte_off_w = $clog2(mask_w);
  localparam int unsigned word_off_w = $clog2(ways_p);

  wbuf_drain_state_e        state_reg;
  logic [paddr_width_p-1:0] paddr_reg;
  logic [way_id_w-1:0]      way_reg;
  logic [data_width_p-1:0]  data_reg;
  logic [mask_w-1:0]        mask_reg;

  logic [paddr_width_p-1:0] in_paddr;
  logic [way_id_w-1:0]      in_way;
  logic [data_width_p-1:0]  in_data;
  logic [mask_w-1:0]        in_mask;

  assign in_mask  = wbuf_entry_i[0 +: mask_w];
  assign in_data  = wbuf_entry_i[mask_w +: data_width_p];
  assign in_way   = wbuf_entry_i[mask_w + data_width_p +: way_id_w];
  assign in_paddr = wbuf_entry_i[mask_w + data_width_p + way_id_w +: paddr_width_p];

  logic held_v;
  logic grant;
  logic accept;

  assign held_v = (state_reg == e_wbuf_drain_req);
  assign grant  = held_v & data_mem_yumi_i;
  // A new entry is taken only when nothing is held or the held one leaves now.
  assign accept = v_i & (~held_v | data_mem_yumi_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= e_wbuf_drain_idle;
      paddr_reg <= '0;
      way_reg   <= '0;
      data_reg  <= '0;
      mask_reg  <= '0;
    end else begin
      case (state_reg)
        e_wbuf_drain_idle: if (v_i) state_reg <= e_wbuf_drain_req;
        e_wbuf_drain_req:  if (grant && !v_i) state_reg <= e_wbuf_drain_idle;
        default:           state_reg <= e_wbuf_drain_idle;
      endcase
      if (accept) begin
        paddr_reg <= in_paddr;
        way_reg   <= in_way;
        data_reg  <= in_data;
        mask_reg  <= in_mask;
      end
    end
  end

  logic [word_off_w-1:0] word;
  logic [way_id_w-1:0]   bank;

  assign word = paddr_reg[byte_off_w +: word_off_w];
  assign bank = way_id_w'(bank_rotate(32'(way_reg), 32'(word), ways_p));

  assign data_mem_v_o     = held_v;
  assign data_mem_index_o = paddr_reg[byte_off_w + word_off_w +: index_w];

  for (genvar gi = 0; gi < int'(ways_p); gi++) begin : g_lane
    logic lane_sel;
    assign lane_sel = held_v & (bank == way_id_w'(gi));
    assign data_mem_bank_mask_o[gi]                   = lane_sel;
    assign data_mem_data_o[gi*data_width_p +: data_width_p] = data_reg;
    assign data_mem_wmask_o[gi*mask_w +: mask_w]      = lane_sel ? mask_reg : '0;
  end

  // Combinational handshakes are gated so every output reads 0 during reset.
  assign yumi_o = reset_n_i & accept;
  assign idle_o = reset_n_i & ~held_v & ~v_i;

  bp_be_dcache_wbuf_drain_starve_ctr #(
    .starve_limit_p(starve_limit_p)
  ) starve_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (held_v & ~data_mem_yumi_i),
    .clr_i    (~held_v | data_mem_yumi_i),
    .sat_o    (priority_o)
  );

endmodule

// File: tb/tb_bp_be_dcache_wbuf_drain.sv
// Directed bench for the wbuf drain: expected writes go into a queue, a
// negedge monitor checks each granted write against it.
module tb_bp_be_dcache_wbuf_drain;

  localparam int DW = 64, PW = 56, WAYS = 8, SETS = 64, LIM = 8;
  localparam int MW = DW / 8, IW = 6, EW = PW + 3 + DW + MW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               v_i = 1'b0;
  logic [EW-1:0]      entry = '0;
  logic               yumi_o;
  logic               dm_v;
  logic               dm_yumi = 1'b0;
  logic [IW-1:0]      dm_index;
  logic [WAYS-1:0]    dm_bank_mask;
  logic [WAYS*DW-1:0] dm_data;
  logic [WAYS*MW-1:0] dm_wmask;
  logic               prio;
  logic               idle;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [IW-1:0]      index;
    logic [WAYS-1:0]    bank_mask;
    logic [WAYS*MW-1:0] wmask;
    logic [DW-1:0]      data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bp_be_dcache_wbuf_drain #(
    .data_width_p(DW), .paddr_width_p(PW), .ways_p(WAYS),
    .sets_p(SETS), .starve_limit_p(LIM)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .wbuf_entry_i(entry),
    .yumi_o(yumi_o), .data_mem_v_o(dm_v), .data_mem_yumi_i(dm_yumi),
    .data_mem_index_o(dm_index), .data_mem_bank_mask_o(dm_bank_mask),
    .data_mem_data_o(dm_data), .data_mem_wmask_o(dm_wmask),
    .priority_o(prio), .idle_o(idle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [PW-1:0] paddr, input logic [2:0] way,
                                       input logic [DW-1:0] data, input logic [MW-1:0] mask);
    return {paddr, way, data, mask};
  endfunction

  task automatic push(input logic [IW-1:0] idx, input logic [WAYS-1:0] bm,
                      input logic [WAYS*MW-1:0] wm, input logic [DW-1:0] d);
    exp_t e;
    e.index = idx; e.bank_mask = bm; e.wmask = wm; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [EW-1:0] e, input logic g);
    v_i = v; entry = e; dm_yumi = g;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every granted write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && dm_v && dm_yumi) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got index %0h bank_mask %0h, expected none", dm_index, dm_bank_mask);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("write index=%0h bank_mask=%0h wmask=%0h", dm_index, dm_bank_mask, dm_wmask);
        chk("wr_index", 64'(dm_index), 64'(e.index));
        chk("wr_bank_mask", 64'(dm_bank_mask), 64'(e.bank_mask));
        chk("wr_wmask", dm_wmask, e.wmask);
        vectors++;
        if (dm_data !== {WAYS{e.data}}) begin
          miscompares++;
          $display("FAIL wr_data: got %0h, expected lanes of %0h", dm_data[DW-1:0], e.data);
        end
      end
    end
  end

  localparam logic [DW-1:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] D0 = 64'hA0A0_0000_0000_0001;
  localparam logic [DW-1:0] D1 = 64'hB1B1_0000_0000_0002;
  localparam logic [DW-1:0] D2 = 64'hC2C2_0000_0000_0003;
  localparam logic [DW-1:0] DS = 64'h5555_6666_7777_8888;
  localparam logic [DW-1:0] DB = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [DW-1:0] DWR = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [DW-1:0] DZ = 64'h0123_4567_89AB_CDEF;

  initial begin
    // Reset: all outputs zero even with v_i asserted.
    drive(1'b1, mk(56'h1048, 3'd3, DA, 8'h0F), 1'b1);
    #12;
    chk("rst_yumi", 64'(yumi_o), 64'd0);
    chk("rst_dm_v", 64'(dm_v), 64'd0);
    chk("rst_prio", 64'(prio), 64'd0);
    chk("rst_idle", 64'(idle), 64'd0);
    chk("rst_bank_mask", 64'(dm_bank_mask), 64'd0);
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_idle", 64'(idle), 64'd1);
    tick();

    // Single entry, immediate grant: index 1, bank 4.
    drive(1'b1, mk(56'h1048, 3'd3, DA, 8'h0F), 1'b1);
    push(6'd1, 8'h10, 64'h0000_000F_0000_0000, DA);
    @(negedge clk);
    chk("a_yumi", 64'(yumi_o), 64'd1);
    tick();
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("a_dm_v", 64'(dm_v), 64'd1);
    chk("a_bank_mask", 64'(dm_bank_mask), 64'h10);
    tick();
    @(negedge clk);
    chk("a_idle", 64'(idle), 64'd1);
    tick();

    // Three back-to-back entries with the grant held.
    drive(1'b1, mk(56'h0040, 3'd0, D0, 8'hFF), 1'b1);
    push(6'd1, 8'h01, 64'h0000_0000_0000_00FF, D0);
    @(negedge clk); chk("b2b_yumi0", 64'(yumi_o), 64'd1); tick();
    drive(1'b1, mk(56'h0088, 3'd2, D1, 8'h3C), 1'b1);
    push(6'd2, 8'h08, 64'h0000_0000_3C00_0000, D1);
    @(negedge clk); chk("b2b_yumi1", 64'(yumi_o), 64'd1); tick();
    drive(1'b1, mk(56'h0FD8, 3'd6, D2, 8'h80), 1'b1);
    push(6'd63, 8'h02, 64'h0000_0000_0000_8000, D2);
    @(negedge clk); chk("b2b_yumi2", 64'(yumi_o), 64'd1); tick();
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("b2b_yumi3", 64'(yumi_o), 64'd0);
    chk("b2b_dm_v3", 64'(dm_v), 64'd1);
    tick();
    @(negedge clk);
    chk("b2b_idle4", 64'(idle), 64'd1);
    chk("b2b_dm_v4", 64'(dm_v), 64'd0);
    tick();

    // Starvation: grant withheld 12 cycles while the next entry waits.
    drive(1'b1, mk(56'h2010, 3'd1, DS, 8'h01), 1'b0);
    push(6'd0, 8'h08, 64'h0000_0000_0100_0000, DS);
    @(negedge clk); chk("s_yumi_idle", 64'(yumi_o), 64'd1); tick();
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, mk(56'h07C8, 3'd5, DB, 8'hF0), 1'b0);
      @(negedge clk);
      chk($sformatf("s_yumi_%0d", k), 64'(yumi_o), 64'd0);
      chk($sformatf("s_prio_%0d", k), 64'(prio), (k >= 9) ? 64'd1 : 64'd0);
      chk($sformatf("s_held_bm_%0d", k), 64'(dm_bank_mask), 64'h08);
      tick();
    end
    drive(1'b1, mk(56'h07C8, 3'd5, DB, 8'hF0), 1'b1);
    push(6'd31, 8'h40, 64'h00F0_0000_0000_0000, DB);
    @(negedge clk);
    chk("s_yumi_grant", 64'(yumi_o), 64'd1);
    chk("s_prio_grant", 64'(prio), 64'd1);
    tick();
    drive(1'b0, '0, 1'b1);
    @(negedge clk); chk("s_prio_after", 64'(prio), 64'd0); tick();
    @(negedge clk); chk("s_idle", 64'(idle), 64'd1); tick();

    // Bank wrap (way 7 + word 7 -> bank 6) then an all-zero mask.
    drive(1'b1, mk(56'h0178, 3'd7, DWR, 8'hA5), 1'b1);
    push(6'd5, 8'h40, 64'h00A5_0000_0000_0000, DWR);
    tick();
    drive(1'b1, mk(56'h0000, 3'd0, DZ, 8'h00), 1'b1);
    push(6'd0, 8'h01, 64'h0, DZ);
    tick();
    drive(1'b0, '0, 1'b1);
    @(negedge clk); chk("z_dm_v", 64'(dm_v), 64'd1); tick();

    // Async reset mid-REQ with priority raised; the held entry is dropped.
    drive(1'b1, mk(56'h3FC0, 3'd4, DA, 8'hFF), 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    for (int k = 1; k <= 9; k++) tick();
    @(negedge clk);
    chk("r_prio_before", 64'(prio), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_dm_v_async", 64'(dm_v), 64'd0);
    chk("r_prio_async", 64'(prio), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    dm_yumi = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("r_no_stale_%0d", k), 64'(dm_v), 64'd0);
      chk($sformatf("r_idle_%0d", k), 64'(idle), 64'd1);
    end
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
